// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared types and constants for elastic pipeline stage buffers
package pipeline_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } stage_state_t;

    localparam int COUNT_W = 2;

    localparam logic [COUNT_W-1:0] CNT_ZERO = 2'd0;
    localparam logic [COUNT_W-1:0] CNT_ONE  = 2'd1;
    localparam logic [COUNT_W-1:0] CNT_TWO  = 2'd2;

endpackage

// File: rtl/pipeline_stage_buf.sv
// rtl/pipeline_stage_buf.sv - elastic valid/ready pipeline stage with optional 2-entry skid
module pipeline_stage_buf
    import pipeline_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = 8,
    parameter int SKID       = 1
) (
    input  logic                  i_clk,
    input  logic                  i_arst,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [CTRL_WIDTH-1:0] i_ctrl,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_flush,
    input  logic                  i_stall,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [CTRL_WIDTH-1:0] o_ctrl,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [COUNT_W-1:0]    o_count
);

    stage_state_t          r_state;
    logic [CTRL_WIDTH-1:0] r_head_ctrl;
    logic [DATA_WIDTH-1:0] r_head_data;
    logic [COUNT_W-1:0]    r_count;
    logic [CTRL_WIDTH-1:0] w_skid_ctrl;
    logic [DATA_WIDTH-1:0] w_skid_data;
    logic                  w_accept;
    logic                  w_take;

    assign o_valid  = (r_state == ST_ONE) || (r_state == ST_TWO);
    assign o_ctrl   = o_valid ? r_head_ctrl : '0;
    assign o_data   = r_head_data;
    assign o_count  = r_count;
    assign w_accept = i_valid & o_ready;
    assign w_take   = o_valid & i_ready & ~i_stall;

    generate
        if (SKID != 0) begin : g_skid
            logic [CTRL_WIDTH-1:0] r_skid_ctrl;
            logic [DATA_WIDTH-1:0] r_skid_data;

            // Ready comes only from registered state, breaking the i_ready -> o_ready chain.
            assign o_ready     = (r_state != ST_TWO) & ~i_stall & ~i_arst;
            assign w_skid_ctrl = r_skid_ctrl;
            assign w_skid_data = r_skid_data;

            always_ff @(posedge i_clk) begin
                if (i_arst) begin
                    r_skid_ctrl <= '0;
                    r_skid_data <= '0;
                end else if (i_flush) begin
                    r_skid_ctrl <= '0;
                end else if (!i_stall) begin
                    if (r_state == ST_ONE && w_accept && !w_take) begin
                        r_skid_ctrl <= i_ctrl;
                        r_skid_data <= i_data;
                    end else if (r_state == ST_TWO && w_take) begin
                        r_skid_ctrl <= '0;
                    end
                end
            end
        end else begin : g_noskid
            assign o_ready     = ~i_stall & ~i_arst & (~o_valid | i_ready);
            assign w_skid_ctrl = '0;
            assign w_skid_data = '0;
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (i_arst) begin
            r_state     <= ST_EMPTY;
            r_head_ctrl <= '0;
            r_head_data <= '0;
            r_count     <= CNT_ZERO;
        end else if (i_flush) begin
            r_state     <= ST_EMPTY;
            r_head_ctrl <= '0;
            r_count     <= CNT_ZERO;
        end else if (!i_stall) begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        r_state     <= ST_ONE;
                        r_head_ctrl <= i_ctrl;
                        r_head_data <= i_data;
                        r_count     <= CNT_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_accept && (w_take || SKID == 0)) begin
                        r_head_ctrl <= i_ctrl;
                        r_head_data <= i_data;
                    end else if (w_accept) begin
                        r_state <= ST_TWO;
                        r_count <= CNT_TWO;
                    end else if (w_take) begin
                        r_state     <= ST_EMPTY;
                        r_head_ctrl <= '0;
                        r_count     <= CNT_ZERO;
                    end
                end
                ST_TWO: begin
                    if (w_take) begin
                        r_state     <= ST_ONE;
                        r_head_ctrl <= w_skid_ctrl;
                        r_head_data <= w_skid_data;
                        r_count     <= CNT_ONE;
                    end
                end
                default: begin
                    r_state     <= ST_EMPTY;
                    r_head_ctrl <= '0;
                    r_count     <= CNT_ZERO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_stage_buf.sv
// tb/tb_pipeline_stage_buf.sv - directed vector bench for pipeline_stage_buf in both skid modes
module tb_pipeline_stage_buf;

    typedef struct {
        logic        arst;
        logic        valid;
        logic [7:0]  ctrl;
        logic [63:0] data;
        logic        flush;
        logic        stall;
        logic        ready;
        logic        e_ready;
        logic        e_valid;
        logic [7:0]  e_ctrl;
        logic [63:0] e_data;
        logic [1:0]  e_count;
    } vec_t;

    logic        clk = 1'b0;
    logic        arst1, valid1, flush1, stall1, rdy_in1;
    logic [7:0]  ctrl1;
    logic [63:0] data1;
    logic        ready1, ovalid1;
    logic [7:0]  octrl1;
    logic [63:0] odata1;
    logic [1:0]  count1;
    logic        arst0, valid0, flush0, stall0, rdy_in0;
    logic [7:0]  ctrl0;
    logic [63:0] data0;
    logic        ready0, ovalid0;
    logic [7:0]  octrl0;
    logic [63:0] odata0;
    logic [1:0]  count0;

    int n_tests = 0;
    int n_fail  = 0;
    vec_t vq1[$];
    vec_t vq0[$];

    always #5 clk = ~clk;

    pipeline_stage_buf #(.DATA_WIDTH(64), .CTRL_WIDTH(8), .SKID(1)) u_dut_skid (
        .i_clk(clk), .i_arst(arst1), .i_valid(valid1), .o_ready(ready1),
        .i_ctrl(ctrl1), .i_data(data1), .i_flush(flush1), .i_stall(stall1),
        .o_valid(ovalid1), .i_ready(rdy_in1), .o_ctrl(octrl1), .o_data(odata1),
        .o_count(count1)
    );

    pipeline_stage_buf #(.DATA_WIDTH(64), .CTRL_WIDTH(8), .SKID(0)) u_dut_reg (
        .i_clk(clk), .i_arst(arst0), .i_valid(valid0), .o_ready(ready0),
        .i_ctrl(ctrl0), .i_data(data0), .i_flush(flush0), .i_stall(stall0),
        .o_valid(ovalid0), .i_ready(rdy_in0), .o_ctrl(octrl0), .o_data(odata0),
        .o_count(count0)
    );

    function automatic vec_t mk(logic a, logic v, logic [7:0] c, logic [63:0] d, logic f,
                                logic s, logic r, logic er, logic ev, logic [7:0] ec,
                                logic [63:0] ed, logic [1:0] en);
        vec_t t;
        t.arst = a; t.valid = v; t.ctrl = c; t.data = d; t.flush = f; t.stall = s;
        t.ready = r; t.e_ready = er; t.e_valid = ev; t.e_ctrl = ec; t.e_data = ed;
        t.e_count = en;
        return t;
    endfunction

    task automatic chk(input string name, input int idx, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s vec %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int idx, input bit sel0);
        @(negedge clk);
        if (sel0) begin
            arst0 = v.arst; valid0 = v.valid; ctrl0 = v.ctrl; data0 = v.data;
            flush0 = v.flush; stall0 = v.stall; rdy_in0 = v.ready;
        end else begin
            arst1 = v.arst; valid1 = v.valid; ctrl1 = v.ctrl; data1 = v.data;
            flush1 = v.flush; stall1 = v.stall; rdy_in1 = v.ready;
        end
        #1;
        chk(sel0 ? "reg.o_ready" : "skid.o_ready", idx, sel0 ? ready0 : ready1, v.e_ready);
        @(posedge clk);
        #1;
        chk(sel0 ? "reg.o_valid" : "skid.o_valid", idx, sel0 ? ovalid0 : ovalid1, v.e_valid);
        chk(sel0 ? "reg.o_ctrl" : "skid.o_ctrl", idx, sel0 ? octrl0 : octrl1, v.e_ctrl);
        chk(sel0 ? "reg.o_data" : "skid.o_data", idx, sel0 ? odata0 : odata1, v.e_data);
        chk(sel0 ? "reg.o_count" : "skid.o_count", idx, sel0 ? count0 : count1, v.e_count);
    endtask

    initial begin
        arst1 = 1'b1; valid1 = 1'b0; ctrl1 = '0; data1 = '0; flush1 = 1'b0;
        stall1 = 1'b0; rdy_in1 = 1'b0;
        arst0 = 1'b1; valid0 = 1'b0; ctrl0 = '0; data0 = '0; flush0 = 1'b0;
        stall0 = 1'b0; rdy_in0 = 1'b0;

        // SKID=1: arst valid ctrl data flush stall ready | ready valid ctrl data count
        vq1.push_back(mk(1, 0, 8'h00, 64'h0,  0, 0, 0,  0, 0, 8'h00, 64'h0, 2'd0));
        for (int k = 0; k < 8; k++)
            vq1.push_back(mk(0, 1, 8'h5A, 64'(k + 1), 0, 0, 1,  1, 1, 8'h5A, 64'(k + 1), 2'd1));
        vq1.push_back(mk(0, 0, 8'h00, 64'h0,  0, 0, 1,  1, 0, 8'h00, 64'h8,  2'd0));
        vq1.push_back(mk(0, 1, 8'h11, 64'hA,  0, 0, 0,  1, 1, 8'h11, 64'hA,  2'd1));
        vq1.push_back(mk(0, 1, 8'h22, 64'hB,  0, 0, 0,  1, 1, 8'h11, 64'hA,  2'd2));
        vq1.push_back(mk(0, 1, 8'hEE, 64'hDEAD, 0, 0, 0, 0, 1, 8'h11, 64'hA,  2'd2));
        vq1.push_back(mk(0, 0, 8'h00, 64'h0,  0, 0, 1,  0, 1, 8'h22, 64'hB,  2'd1));
        vq1.push_back(mk(0, 0, 8'h00, 64'h0,  0, 0, 1,  1, 0, 8'h00, 64'hB,  2'd0));
        vq1.push_back(mk(0, 1, 8'h33, 64'hD,  0, 0, 0,  1, 1, 8'h33, 64'hD,  2'd1));
        vq1.push_back(mk(0, 1, 8'h44, 64'hE,  0, 0, 0,  1, 1, 8'h33, 64'hD,  2'd2));
        vq1.push_back(mk(0, 1, 8'h55, 64'hC,  1, 0, 0,  0, 0, 8'h00, 64'hD,  2'd0));
        vq1.push_back(mk(0, 0, 8'h00, 64'h0,  0, 0, 1,  1, 0, 8'h00, 64'hD,  2'd0));
        vq1.push_back(mk(0, 1, 8'h66, 64'hF,  0, 0, 0,  1, 1, 8'h66, 64'hF,  2'd1));
        vq1.push_back(mk(0, 1, 8'h77, 64'h10, 1, 0, 1,  1, 0, 8'h00, 64'hF,  2'd0));
        vq1.push_back(mk(0, 1, 8'h88, 64'h20, 0, 0, 0,  1, 1, 8'h88, 64'h20, 2'd1));
        for (int k = 0; k < 3; k++)
            vq1.push_back(mk(0, 1, 8'h99, 64'h21, 0, 1, 1,  0, 1, 8'h88, 64'h20, 2'd1));
        vq1.push_back(mk(0, 1, 8'h99, 64'h21, 0, 0, 1,  1, 1, 8'h99, 64'h21, 2'd1));
        vq1.push_back(mk(0, 1, 8'hFF, 64'h30, 0, 0, 1,  1, 1, 8'hFF, 64'h30, 2'd1));
        vq1.push_back(mk(0, 0, 8'h00, 64'h0,  0, 0, 1,  1, 0, 8'h00, 64'h30, 2'd0));
        vq1.push_back(mk(0, 1, 8'h01, 64'h40, 0, 0, 0,  1, 1, 8'h01, 64'h40, 2'd1));
        vq1.push_back(mk(0, 1, 8'h02, 64'h41, 0, 0, 0,  1, 1, 8'h01, 64'h40, 2'd2));
        vq1.push_back(mk(1, 1, 8'h03, 64'h42, 0, 0, 0,  0, 0, 8'h00, 64'h0,  2'd0));
        vq1.push_back(mk(0, 0, 8'h00, 64'h0,  0, 0, 0,  1, 0, 8'h00, 64'h0,  2'd0));
        vq1.push_back(mk(0, 1, 8'h03, 64'h50, 0, 0, 1,  1, 1, 8'h03, 64'h50, 2'd1));
        vq1.push_back(mk(0, 0, 8'h00, 64'h0,  0, 0, 1,  1, 0, 8'h00, 64'h50, 2'd0));

        // SKID=0: combinational ready follows i_ready while the head is occupied
        vq0.push_back(mk(1, 0, 8'h00, 64'h0,  0, 0, 0,  0, 0, 8'h00, 64'h0,  2'd0));
        for (int k = 0; k < 8; k++)
            vq0.push_back(mk(0, 1, 8'h5A, 64'(k + 1), 0, 0, 1,  1, 1, 8'h5A, 64'(k + 1), 2'd1));
        vq0.push_back(mk(0, 1, 8'h11, 64'hA,  0, 0, 0,  0, 1, 8'h5A, 64'h8,  2'd1));
        vq0.push_back(mk(0, 1, 8'h11, 64'hA,  0, 0, 1,  1, 1, 8'h11, 64'hA,  2'd1));
        vq0.push_back(mk(0, 0, 8'h00, 64'h0,  0, 0, 0,  0, 1, 8'h11, 64'hA,  2'd1));
        vq0.push_back(mk(0, 0, 8'h00, 64'h0,  0, 0, 1,  1, 0, 8'h00, 64'hA,  2'd0));
        vq0.push_back(mk(0, 1, 8'hFF, 64'hB,  0, 1, 0,  0, 0, 8'h00, 64'hA,  2'd0));
        vq0.push_back(mk(0, 1, 8'hFF, 64'hB,  0, 0, 0,  1, 1, 8'hFF, 64'hB,  2'd1));
        vq0.push_back(mk(0, 1, 8'h22, 64'hC,  1, 0, 1,  1, 0, 8'h00, 64'hB,  2'd0));

        foreach (vq1[i]) apply(vq1[i], i, 1'b0);
        foreach (vq0[i]) apply(vq0[i], i, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_stage_buf.md
Name: pipeline_stage_buf

Overview:
Parametrised elastic pipeline-stage register, the successor to the fixed-field stall-only stage registers. It carries an opaque payload split into two parts:
- a control field (reg_we, mem_we, result_src, ...), which is zeroed whenever the slot holds a bubble;
- a data field (PCs, ALU result, immediates, ...).
The stage uses valid/ready handshakes, synchronous flush, a global stall, and an optional 2-entry skid mode. Skid mode removes the combinational ready path between adjacent stages while keeping full throughput. It sits between any two core stages (e.g. execute->memory) and replaces the hand-written per-stage registers.

Parameters:
- DATA_WIDTH, 64, width of data payload (held on bubble/flush).
- CTRL_WIDTH, 8, width of control payload (forced to 0 on bubble/flush/reset).
- SKID, 1, 1 = 2-entry skid buffer with registered o_ready; 0 = single register with combinational o_ready.

Ports:
- i_clk  in  1  clock, rising edge.
- i_arst  in  1  reset, synchronous, active-high.
- i_valid  in  1  upstream entry valid.
- o_ready  out  1  stage can accept this cycle.
- i_ctrl  in  CTRL_WIDTH  upstream control payload.
- i_data  in  DATA_WIDTH  upstream data payload.
- i_flush  in  1  kill all held entries and the incoming one.
- i_stall  in  1  global hold: no transfer on either side.
- o_valid  out  1  head entry valid.
- i_ready  in  1  downstream accepts head.
- o_ctrl  out  CTRL_WIDTH  head control, 0 when o_valid=0.
- o_data  out  DATA_WIDTH  head data.
- o_count  out  2  occupancy 0..2 (0..1 when SKID=0).

Behaviour:
- Handshake terms:
  - accept = i_valid & o_ready.
  - take = o_valid & i_ready & ~i_stall.
  - i_valid may be asserted without waiting on o_ready. Payload must stay stable while i_valid=1 & o_ready=0.
- Priority order: i_arst > i_flush > i_stall > handshake.
- Reset, in the clock cycle i_arst is sampled high:
  - o_valid=0, o_ctrl=0, o_data=0, o_count=0, skid entry cleared, state EMPTY.
  - o_ready=0 while i_arst=1.
  - o_ready=~i_stall in the first cycle after release.
- Flush (i_flush=1, not in reset):
  - next state EMPTY; all valids cleared; all ctrl fields <=0; data fields hold.
  - o_ready is not forced low, but any accept in that cycle is discarded.
  - take may be observed by downstream in the flush cycle; the entry is still removed.
- Stall: all state, valids and payloads hold; o_ready=0. Downstream must ignore i_ready.
- SKID=1 states (package enum): EMPTY (0 entries), ONE (head valid), TWO (head+skid valid).
  - o_ready = (state!=TWO) & ~i_stall & ~i_arst. It depends only on registered state and i_stall, with no path from i_ready.
  - EMPTY: accept -> ONE, head<=in.
  - ONE:
    - accept&take -> ONE, head<=in.
    - accept&~take -> TWO, skid<=in.
    - ~accept&take -> EMPTY, head ctrl<=0.
    - else hold.
  - TWO:
    - take -> ONE, head<=skid, skid ctrl<=0.
    - else hold. No accept is possible.
  - Order is preserved: the skid entry is always younger than head.
- SKID=0: states EMPTY/ONE only.
  - o_ready = ~i_stall & ~i_arst & (~o_valid | i_ready). This is a combinational path from i_ready.
  - accept -> head<=in, state ONE, regardless of take.
  - take&~accept -> EMPTY, head ctrl<=0.
- Latency: 1 cycle from accept to o_valid when empty. Throughput is 1 entry/cycle in both modes while downstream is ready.
- o_count = number of valid entries, registered, updated on the same edge as the state.
- The state encoding has no illegal reachable state. An unused encoding goes to EMPTY with ctrl zeroed.

Decomposition:
- Package pipeline_pkg: typedef enum logic [1:0] stage_state_t {ST_EMPTY, ST_ONE, ST_TWO}. Also localparam constants for count width.
- No sub-module. Entry storage and the state machine live in one module. A generate block on SKID selects the o_ready expression and instantiates or omits the skid entry.

Test Plan:
- Reset then stream: i_valid=1 with ctrl=0x5A, data=i+1 for 8 cycles, i_ready=1 -> o_valid from cycle 1; o_data sequence 1..8 back-to-back; o_count=1; o_ready=1 throughout (both SKID values).
- Backpressure, SKID=1:
  - send A,B with i_ready=0 -> o_count=2, o_ready=0, o_data=A.
  - raise i_ready -> A, then B, on consecutive cycles.
  - o_ready=1 again one cycle after A leaves; no loss or duplication.
- Flush while in TWO: i_flush=1 with i_valid=1 data C -> next cycle o_valid=0, o_ctrl=0, o_count=0; C never appears.
- Stall: hold i_stall=1 for 3 cycles with i_valid=1, i_ready=1 -> o_ready=0; o_data, o_ctrl and o_count unchanged; no transfer. Traffic resumes on the cycle after release.
- Bubble: single entry ctrl=0xFF taken with no new input -> next cycle o_valid=0, o_ctrl=0x00, o_data retains the last value.
- Reset mid-operation in state TWO: i_arst=1 for 1 cycle -> next cycle all outputs 0, o_count=0; o_ready=1 on the following cycle with i_stall=0.
